mem_access_ctrl: RTL and testbench

//  CU-side initiator for the byte-addressed RAM's Enable/OpCode/MFC/MSET handshake.

---
 rtl/mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Control-unit side initiator for the byte-addressed RAM
//               Enable/OpCode/MFC/MSET handshake. Accepts one request,
//               checks opcode legality and alignment, splits LDD/STD into
//               two word accesses (addr, addr+4) and reports load data or a
//               fault code for the trap logic.
// Ports       : Clk/Clr            clock, async active-low reset
//               Req/ReqOp/ReqAddr  request (sampled only while Ready=1)
//               WrData0/WrData1    store data (second word for STD)
//               Ready/Done         idle flag, one-cycle completion pulse
//               Fault/FaultCode    00 illegal, 01 misaligned, 10 MSET, 11 timeout
//               RdData0/RdData1    load results (RdData1 = second LDD word)
//               Enable/OpCode/MAR_Address/MDR_DataIn  memory bus outputs
//               MDR_DataOut/MFC/MSET                  memory bus inputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Req,
    input  logic [5:0]  ReqOp,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] WrData0,
    input  logic [31:0] WrData1,
    output logic        Ready,
    output logic        Done,
    output logic        Fault,
    output logic [1:0]  FaultCode,
    output logic [31:0] RdData0,
    output logic [31:0] RdData1,
    output logic        Enable,
    output logic [5:0]  OpCode,
    output logic [31:0] MAR_Address,
    output logic [31:0] MDR_DataIn,
    input  logic [31:0] MDR_DataOut,
    input  logic        MFC,
    input  logic        MSET
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SETUP = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [5:0] c_OP_LD   = 6'b000000;
    localparam logic [5:0] c_OP_LDUB = 6'b000001;
    localparam logic [5:0] c_OP_LDUH = 6'b000010;
    localparam logic [5:0] c_OP_LDD  = 6'b000011;
    localparam logic [5:0] c_OP_ST   = 6'b000100;
    localparam logic [5:0] c_OP_STB  = 6'b000101;
    localparam logic [5:0] c_OP_STH  = 6'b000110;
    localparam logic [5:0] c_OP_STD  = 6'b000111;
    localparam logic [5:0] c_OP_LDSB = 6'b001001;
    localparam logic [5:0] c_OP_LDSH = 6'b001010;

    localparam logic [1:0] c_FC_ILLEGAL  = 2'b00;
    localparam logic [1:0] c_FC_MISALIGN = 2'b01;
    localparam logic [1:0] c_FC_STORE    = 2'b10;
    localparam logic [1:0] c_FC_TIMEOUT  = 2'b11;

    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [5:0]         r_op;
    logic               r_second;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_wdata1;
    logic               r_fault;
    logic [1:0]         r_code;
    logic [31:0]        r_rd0;
    logic [31:0]        r_rd1;
    logic               r_enable;
    logic [5:0]         r_opcode;
    logic [31:0]        r_mar;
    logic [31:0]        r_mdr;

    logic               w_legal;
    logic               w_aligned;
    logic [5:0]         w_mem_op;
    logic               w_is_load;
    logic               w_is_dbl;

    // Request decode, evaluated on the live request inputs while idle.
    always_comb begin
        w_legal   = 1'b1;
        w_aligned = 1'b1;
        w_mem_op  = ReqOp;
        case (ReqOp)
            c_OP_LD, c_OP_ST:              w_aligned = (ReqAddr[1:0] == 2'b00);
            c_OP_LDD: begin
                w_aligned = (ReqAddr[2:0] == 3'b000);
                w_mem_op  = c_OP_LD;
            end
            c_OP_STD: begin
                w_aligned = (ReqAddr[2:0] == 3'b000);
                w_mem_op  = c_OP_ST;
            end
            c_OP_LDUH, c_OP_STH, c_OP_LDSH: w_aligned = ~ReqAddr[0];
            c_OP_LDUB, c_OP_STB, c_OP_LDSB: w_aligned = 1'b1;
            default:                        w_legal   = 1'b0;
        endcase
    end

    // Properties of the latched request.
    always_comb begin
        w_is_dbl  = (r_op == c_OP_LDD) || (r_op == c_OP_STD);
        w_is_load = (r_op == c_OP_LD)   || (r_op == c_OP_LDUB) || (r_op == c_OP_LDUH) ||
                    (r_op == c_OP_LDD)  || (r_op == c_OP_LDSB) || (r_op == c_OP_LDSH);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state  <= c_IDLE;
            r_op     <= '0;
            r_second <= 1'b0;
            r_cnt    <= '0;
            r_wdata1 <= '0;
            r_fault  <= 1'b0;
            r_code   <= '0;
            r_rd0    <= '0;
            r_rd1    <= '0;
            r_enable <= 1'b0;
            r_opcode <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Req) begin
                        r_op     <= ReqOp;
                        r_wdata1 <= WrData1;
                        r_second <= 1'b0;
                        r_fault  <= 1'b0;
                        r_code   <= '0;
                        if (!w_legal) begin
                            r_fault <= 1'b1;
                            r_code  <= c_FC_ILLEGAL;
                            r_state <= c_DONE;
                        end else if (!w_aligned) begin
                            r_fault <= 1'b1;
                            r_code  <= c_FC_MISALIGN;
                            r_state <= c_DONE;
                        end else begin
                            r_mar    <= ReqAddr;
                            r_mdr    <= WrData0;
                            r_opcode <= w_mem_op;
                            r_state  <= c_SETUP;
                        end
                    end
                end
                c_SETUP: begin
                    // The bus has been stable for a full cycle; one level
                    // change of Enable launches exactly one access.
                    r_enable <= ~r_enable;
                    r_cnt    <= '0;
                    r_state  <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_cnt == '0) begin
                        // Settle cycle: MFC from the previous access may
                        // still be high, so nothing is sampled here.
                        r_cnt <= c_CNT_ONE;
                    end else if (MSET) begin
                        r_fault <= 1'b1;
                        r_code  <= c_FC_STORE;
                        r_state <= c_DONE;
                    end else if (MFC) begin
                        if (w_is_load) begin
                            if (r_second) begin
                                r_rd1 <= MDR_DataOut;
                            end else begin
                                r_rd0 <= MDR_DataOut;
                            end
                        end
                        if (w_is_dbl && !r_second) begin
                            r_second <= 1'b1;
                            r_mar    <= r_mar + 32'd4;
                            r_mdr    <= r_wdata1;
                            r_state  <= c_SETUP;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_fault <= 1'b1;
                        r_code  <= c_FC_TIMEOUT;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Ready is forced low while reset is asserted so every output reads 0.
    assign Ready       = (r_state == c_IDLE) && Clr;
    assign Done        = (r_state == c_DONE);
    assign Fault       = r_fault;
    assign FaultCode   = r_code;
    assign RdData0     = r_rd0;
    assign RdData1     = r_rd1;
    assign Enable      = r_enable;
    assign OpCode      = r_opcode;
    assign MAR_Address = r_mar;
    assign MDR_DataIn  = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Scoreboard bench for mem_access_ctrl. A byte-array memory
//               responder answers Enable toggles; a request-level reference
//               model predicts each completion; a monitor compares on Done.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;
    localparam int M_OK    = 0;
    localparam int M_MSET  = 1;
    localparam int M_BOTH  = 2;
    localparam int M_NONE  = 3;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        Req = 1'b0;
    logic [5:0]  ReqOp = '0;
    logic [31:0] ReqAddr = '0;
    logic [31:0] WrData0 = '0;
    logic [31:0] WrData1 = '0;
    logic [31:0] MDR_DataOut = '0;
    logic        MFC = 1'b0;
    logic        MSET = 1'b0;
    logic        Ready, Done, Fault, Enable;
    logic [1:0]  FaultCode;
    logic [31:0] RdData0, RdData1, MAR_Address, MDR_DataIn;
    logic [5:0]  OpCode;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Clr(Clr), .Req(Req), .ReqOp(ReqOp), .ReqAddr(ReqAddr),
        .WrData0(WrData0), .WrData1(WrData1), .Ready(Ready), .Done(Done),
        .Fault(Fault), .FaultCode(FaultCode), .RdData0(RdData0), .RdData1(RdData1),
        .Enable(Enable), .OpCode(OpCode), .MAR_Address(MAR_Address),
        .MDR_DataIn(MDR_DataIn), .MDR_DataOut(MDR_DataOut), .MFC(MFC), .MSET(MSET)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory responder (bus level) ----------------
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    typedef struct { int mode; int delay; } acc_t;
    acc_t resp_q[$];

    task automatic mem_access(input logic [7:0] a, input logic [5:0] opc,
                              input logic [31:0] din, input int mode);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
        MDR_DataOut = $urandom();
        case (opc)
            6'd0:  MDR_DataOut = {mem[a], mem[a1], mem[a2], mem[a3]};
            6'd1:  MDR_DataOut = {24'd0, mem[a]};
            6'd2:  MDR_DataOut = {16'd0, mem[a], mem[a1]};
            6'd9:  MDR_DataOut = {{24{mem[a][7]}}, mem[a]};
            6'd10: MDR_DataOut = {{16{mem[a][7]}}, mem[a], mem[a1]};
            6'd4: if (mode == M_OK) begin
                mem[a] = din[31:24]; mem[a1] = din[23:16]; mem[a2] = din[15:8]; mem[a3] = din[7:0];
            end
            6'd5: if (mode == M_OK) mem[a] = din[7:0];
            6'd6: if (mode == M_OK) begin mem[a] = din[15:8]; mem[a1] = din[7:0]; end
            default: ;
        endcase
    endtask

    logic en_seen = 1'b0;
    bit   pend = 0;
    int   pcnt = 0;
    int   pmode = 0;
    acc_t racc;

    always @(negedge Clk) begin
        if (!Clr) begin
            en_seen = Enable; pend = 0; MFC = 1'b0; MSET = 1'b0;
            resp_q.delete();
        end else begin
            if (Enable !== en_seen) begin
                en_seen = Enable;
                if (resp_q.size() > 0) racc = resp_q.pop_front();
                else begin racc.mode = M_OK; racc.delay = 0; end
                MFC = 1'b0; MSET = 1'b0;
                pmode = racc.mode; pcnt = racc.delay; pend = 1;
                mem_access(MAR_Address[7:0], OpCode, MDR_DataIn, racc.mode);
            end
            if (pend) begin
                if (pcnt == 0) begin
                    pend = 0;
                    case (pmode)
                        M_OK:   MFC = 1'b1;
                        M_MSET: MSET = 1'b1;
                        M_BOTH: begin MFC = 1'b1; MSET = 1'b1; end
                        default: ;
                    endcase
                end else pcnt--;
            end
        end
    end

    // ---------------- reference model (request level) ----------------
    typedef struct {
        logic fault; logic [1:0] code; logic [31:0] rd0; logic [31:0] rd1;
        int toggles; int lat; logic [31:0] last_mar; logic [5:0] last_opc;
    } exp_t;
    exp_t sb_q[$];
    logic [31:0] m_rd0 = '0;
    logic [31:0] m_rd1 = '0;

    function automatic bit legal(input logic [5:0] op);
        return (op <= 6'd10) && (op != 6'd8);
    endfunction

    function automatic int align_of(input logic [5:0] op);
        case (op)
            6'd0, 6'd4:        return 4;
            6'd3, 6'd7:        return 8;
            6'd2, 6'd6, 6'd10: return 2;
            default:           return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int nb, input bit sx);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[8'(addr + 32'(i))]);
        if (sx && nb < 4 && v[nb*8-1]) v = v | ~((32'd1 << (nb*8)) - 32'd1);
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input int nb, input logic [31:0] d);
        for (int i = 0; i < nb; i++) ref_mem[8'(addr + 32'(i))] = 8'(d >> (8*(nb-1-i)));
    endtask

    task automatic model_push(input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input int m0, input int d0, input int m1, input int d1);
        exp_t e;
        int nacc, nb, mm, dd;
        bit is_ld, sx;
        logic [31:0] aa;
        e.fault = 1'b0; e.code = 2'd0; e.toggles = 0; e.lat = -1; e.last_mar = '0; e.last_opc = '0;
        if (!legal(op)) begin
            e.fault = 1'b1; e.code = 2'd0;
        end else if ((addr % align_of(op)) != 0) begin
            e.fault = 1'b1; e.code = 2'd1;
        end else begin
            nacc  = (op == 6'd3 || op == 6'd7) ? 2 : 1;
            is_ld = (op == 6'd0 || op == 6'd1 || op == 6'd2 || op == 6'd3 || op == 6'd9 || op == 6'd10);
            nb    = (op == 6'd1 || op == 6'd5 || op == 6'd9) ? 1 :
                    (op == 6'd2 || op == 6'd6 || op == 6'd10) ? 2 : 4;
            sx    = (op == 6'd9 || op == 6'd10);
            for (int i = 0; i < nacc; i++) begin
                mm = (i == 0) ? m0 : m1;
                dd = (i == 0) ? d0 : d1;
                aa = addr + 32'(4*i);
                e.toggles  = i + 1;
                e.last_mar = aa;
                e.last_opc = (op == 6'd3) ? 6'd0 : (op == 6'd7) ? 6'd4 : op;
                // first MFC sample is two cycles after the toggle is seen
                e.lat = (mm == M_NONE) ? TIMEOUT + 1 : ((dd < 1) ? 1 : dd) + 1;
                if (mm == M_MSET || mm == M_BOTH) begin e.fault = 1'b1; e.code = 2'd2; break; end
                if (mm == M_NONE) begin e.fault = 1'b1; e.code = 2'd3; break; end
                if (is_ld) begin
                    if (i == 0) m_rd0 = ref_read(aa, nb, sx);
                    else        m_rd1 = ref_read(aa, nb, sx);
                end else begin
                    ref_write(aa, nb, (i == 0) ? wd0 : wd1);
                end
            end
        end
        e.rd0 = m_rd0; e.rd1 = m_rd1;
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic        mon_en = 1'b0;
    int          cyc = 0, last_tog = 0, togs = 0;
    logic [31:0] t_mar = '0;
    logic [5:0]  t_opc = '0;
    bit          post = 0;
    logic [2:0]  post_fc = '0;
    exp_t        me;

    always @(negedge Clk) begin
        cyc++;
        if (!Clr) begin
            mon_en = Enable; togs = 0; post = 0;
        end else begin
            if (post) begin
                post = 0;
                check("ready_after_done", 32'(Ready), 32'd1);
                check("done_one_cycle", 32'(Done), 32'd0);
                check("fault_hold", 32'({Fault, FaultCode}), 32'(post_fc));
            end
            if (Enable !== mon_en) begin
                mon_en = Enable; togs++; last_tog = cyc; t_mar = MAR_Address; t_opc = OpCode;
            end
            if (Done) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got Done=1 expected no completion");
                end else begin
                    me = sb_q.pop_front();
                    check("fault", 32'(Fault), 32'(me.fault));
                    check("fault_code", 32'(FaultCode), 32'(me.code));
                    check("rd_data0", RdData0, me.rd0);
                    check("rd_data1", RdData1, me.rd1);
                    check("enable_toggles", 32'(togs), 32'(me.toggles));
                    if (me.toggles > 0) begin
                        check("latency_from_toggle", 32'(cyc - last_tog), 32'(me.lat));
                        check("last_mar", t_mar, me.last_mar);
                        check("last_opcode", 32'(t_opc), 32'(me.last_opc));
                    end
                    togs = 0; post = 1; post_fc = {me.fault, me.code};
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input int m0, input int d0, input int m1, input int d1,
                         input int hold, input bit expect_done);
        int   g;
        acc_t a;
        g = 0;
        while (Ready !== 1'b1 && g < 100) begin @(negedge Clk); g++; end
        if (Ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL ready_wait: got Ready=%b expected 1 within 100 cycles", Ready);
        end
        // holding Req past the return to idle would start a second request
        if (!legal(op) || (addr % align_of(op)) != 0) hold = 0;
        resp_q.delete();
        a.mode = m0; a.delay = d0; resp_q.push_back(a);
        a.mode = m1; a.delay = d1; resp_q.push_back(a);
        if (expect_done) model_push(op, addr, wd0, wd1, m0, d0, m1, d1);
        Req = 1'b1; ReqOp = op; ReqAddr = addr; WrData0 = wd0; WrData1 = wd1;
        @(negedge Clk);
        repeat (hold) @(negedge Clk);
        Req = 1'b0; ReqOp = 6'($urandom()); ReqAddr = $urandom(); WrData0 = $urandom();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb_q.size() != 0 || Ready !== 1'b1) && g < 500) begin @(negedge Clk); g++; end
        if (sb_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: got %0d pending completions expected 0", sb_q.size());
        end
        repeat (2) @(negedge Clk);
    endtask

    int mode0, mode1, r;
    logic [5:0]  rop;
    logic [31:0] raddr, sa, sb;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom()); ref_mem[i] = mem[i];
        end
        mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
        for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];

        Clr = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_ready_low", 32'(Ready), 32'd0);
        check("reset_enable", 32'(Enable), 32'd0);
        check("reset_opcode", 32'(OpCode), 32'd0);
        check("reset_mar", MAR_Address, 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_fault", 32'(Fault), 32'd0);
        check("reset_rd0", RdData0, 32'd0);
        #1 Clr = 1'b1;
        @(negedge Clk);
        check("ready_after_reset", 32'(Ready), 32'd1);

        // directed cases
        issue(6'd0, 32'h010, 32'h0, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd7, 32'h020, 32'h11112222, 32'h33334444, M_OK, 1, M_OK, 2, 0, 1);
        issue(6'd3, 32'h020, 32'h0, 32'h0, M_OK, 0, M_OK, 3, 1, 1);
        issue(6'd6, 32'h031, 32'h5555AAAA, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd3, 32'h024, 32'h0, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd8, 32'h040, 32'h0, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd63, 32'h040, 32'h0, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd4, 32'h040, 32'hCAFEF00D, 32'h0, M_MSET, 1, M_OK, 0, 0, 1);
        issue(6'd4, 32'h044, 32'hCAFEF00D, 32'h0, M_BOTH, 0, M_OK, 0, 2, 1);
        issue(6'd0, 32'h048, 32'h0, 32'h0, M_NONE, 0, M_OK, 0, 0, 1);
        issue(6'd7, 32'h050, 32'hA5A5A5A5, 32'h5A5A5A5A, M_OK, 0, M_MSET, 2, 0, 1);
        issue(6'd3, 32'h050, 32'h0, 32'h0, M_OK, 2, M_NONE, 0, 0, 1);
        issue(6'd9, 32'h013, 32'h0, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd10, 32'h012, 32'h0, 32'h0, M_OK, 3, M_OK, 0, 0, 1);

        // randomized requests
        for (int n = 0; n < 60; n++) begin
            rop   = 6'($urandom_range(0, 11));
            raddr = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) raddr = raddr & ~32'd7;
            r = $urandom_range(0, 11);
            mode0 = (r == 0) ? M_MSET : (r == 1) ? M_BOTH : (r == 2) ? M_NONE : M_OK;
            r = $urandom_range(0, 11);
            mode1 = (r == 0) ? M_MSET : (r == 1) ? M_BOTH : (r == 2) ? M_NONE : M_OK;
            issue(rop, raddr, $urandom(), $urandom(), mode0, $urandom_range(0, 3),
                  mode1, $urandom_range(0, 3), $urandom_range(0, 2), 1);
        end
        drain();

        // reset while the first STD half is in flight: no completion,
        // first word stays written
        sa = $urandom(); sb = $urandom();
        issue(6'd7, 32'h080, sa, sb, M_OK, 3, M_OK, 0, 0, 0);
        @(negedge Clk);
        #1 Clr = 1'b0;
        ref_write(32'h080, 4, sa);
        #2;
        check("abort_ready_low", 32'(Ready), 32'd0);
        check("abort_opcode", 32'(OpCode), 32'd0);
        check("abort_enable", 32'(Enable), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        @(negedge Clk);
        #1 Clr = 1'b1;
        repeat (4) @(negedge Clk);
        check("abort_ready_high", 32'(Ready), 32'd1);
        check("abort_opcode_after", 32'(OpCode), 32'd0);
        check("abort_rd0_cleared", RdData0, 32'd0);
        m_rd0 = '0; m_rd1 = '0;
        issue(6'd0, 32'h080, 32'h0, 32'h0, M_OK, 0, M_OK, 0, 0, 1);
        issue(6'd0, 32'h084, 32'h0, 32'h0, M_OK, 1, M_OK, 0, 0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
